ftdi_tx_arbiter: RTL and testbench

//  Shares the single FTDI byte-transmit path between N byte-stream requesters.

---
 rtl/ftdi_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/ftdi_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ftdi_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared constants and state encoding for the FTDI transmit arbiter.
package ftdi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_HDR   = 3'd2,
    ST_DATA  = 3'd3
  } state_t;

  // Index width for n requesters; never below one bit so N_REQ=1 still has a field.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, modulo N_REQ.
module rr_arbiter
  import ftdi_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Shares the FTDI byte-transmit path between N_REQ byte streams. Round-robin arbitration,
// grant held for a whole packet (or MAX_LEN bytes), aborted after TIMEOUT cycles without ack.
// Define FTDI_ARB_HEADER_EN to prefix each grant with a {HDR_TAG, channel} header byte.
module ftdi_tx_arbiter
  import ftdi_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [N_REQ-1:0]        in_req_valid,
  input  logic [BYTE_W*N_REQ-1:0] in_req_data,
  input  logic [N_REQ-1:0]        in_req_last,
  output logic [N_REQ-1:0]        out_req_ready,
  output logic [BYTE_W-1:0]       out_link_data,
  output logic                    out_link_data_rdy,
  input  logic                    in_link_ack,
  output logic [N_REQ-1:0]        out_grant,
  output logic                    out_busy,
  output logic                    out_timeout
);

  localparam int unsigned IDX_W = idx_width(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic [IDX_W-1:0]  next_ptr;
  logic              sel_valid;
  logic              sel_last;
  logic [BYTE_W-1:0] sel_data;
  logic              active;
  logic              link_rdy;
  logic              link_write;
  logic              expire;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .req  (in_req_valid),
    .ptr  (rr_ptr_q),
    .idx  (win_idx),
    .found(win_found)
  );

  assign sel_valid = in_req_valid[gnt_q];
  assign sel_last  = in_req_last[gnt_q];
  assign sel_data  = in_req_data[BYTE_W*gnt_q +: BYTE_W];
  assign next_ptr  = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

  // Link-side handshake; a write never happens in a reset cycle.
  always_comb begin
    active   = (state_q == ST_DATA);
    link_rdy = (state_q == ST_DATA) && sel_valid;
`ifdef FTDI_ARB_HEADER_EN
    if (state_q == ST_HDR) begin
      active   = 1'b1;
      link_rdy = 1'b1;
    end
`endif
  end

  assign link_write = in_link_ack && link_rdy && !in_rst;
  // Ack in the expiry cycle wins, so expiry requires the absence of a write.
  assign expire = (TIMEOUT != 0) && active && !link_write && !in_rst &&
                  (tmo_q == TMO_W'(TIMEOUT - 1));
  assign out_timeout = expire;

  // Output mux: header byte, selected lane, or idle zeros.
  always_comb begin
    out_link_data     = '0;
    out_link_data_rdy = link_rdy;
    out_req_ready     = '0;
    out_grant         = '0;
    out_busy          = active;
    if (active) begin
      out_grant[gnt_q] = 1'b1;
    end
    unique case (state_q)
`ifdef FTDI_ARB_HEADER_EN
      ST_HDR: out_link_data = {HDR_TAG, 4'(gnt_q)};
`endif
      ST_DATA: begin
        out_link_data        = sel_data;
        out_req_ready[gnt_q] = link_write;
      end
      default: ;
    endcase
  end

  // Next-state logic for the grant FSM, byte counter and ack timer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (|in_req_valid) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        tmo_d = '0;
        if (win_found) begin
          gnt_d = win_idx;
`ifdef FTDI_ARB_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_DATA;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef FTDI_ARB_HEADER_EN
      ST_HDR: begin
        if (link_write) begin
          state_d = ST_DATA;
          tmo_d   = '0;
        end else if (expire) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      ST_DATA: begin
        if (link_write) begin
          cnt_d = cnt_q + CNT_W'(1);
          tmo_d = '0;
          if (sel_last || (cnt_q == CNT_W'(MAX_LEN - 1))) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
            cnt_d    = '0;
          end
        end else if (expire) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed self-checking bench for ftdi_tx_arbiter (N_REQ=4, MAX_LEN=4, TIMEOUT=8).
// Inputs are driven 1 ns after the rising edge, outputs sampled 3 ns after it.
module tb_ftdi_tx_arbiter;

`ifdef FTDI_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic [7:0]  link_data;
  logic        link_rdy, link_ack, busy, timeout;

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(
    .N_REQ  (4),
    .MAX_LEN(4),
    .TIMEOUT(8)
  ) dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_req_valid     (req_valid),
    .in_req_data      (req_data),
    .in_req_last      (req_last),
    .out_req_ready    (req_ready),
    .out_link_data    (link_data),
    .out_link_data_rdy(link_rdy),
    .in_link_ack      (link_ack),
    .out_grant        (grant),
    .out_busy         (busy),
    .out_timeout      (timeout)
  );

  // Requester model: per-lane byte lists consumed on valid&ready.
  logic [7:0] src_mem[4][16];
  bit         src_lst[4][16];
  int         src_len[4], src_pos[4], rdy_cnt[4], gap_cnt[4];
  int         gap_req, gap_after, gap_len;
  logic [7:0] wr_log[$], exp_wr[$];
  int         grant_log[$], exp_gnt[$];
  int         cyc, ack_period, ack_rel, busy_start, tmo_cnt, tmo_cyc, hold_lo;
  bit         ack_raw, busy_prev;
  logic [3:0] prev_grant;
  int         errors, checks;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0; src_pos[i] = 0; rdy_cnt[i] = 0; gap_cnt[i] = 0;
    end
    gap_req = -1; gap_after = 0; gap_len = 0;
    wr_log.delete(); exp_wr.delete(); grant_log.delete(); exp_gnt.delete();
    ack_period = 0; ack_rel = -1; ack_raw = 1'b0;
    busy_start = -1; tmo_cnt = 0; tmo_cyc = -1; hold_lo = 0;
    busy_prev = 1'b0; prev_grant = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; link_ack = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit l);
    src_mem[r][src_len[r]] = b;
    src_lst[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic exp_hdr(input int r);
    if (HDR_EN) exp_wr.push_back({4'hA, 4'(r)});
  endtask

  // One clock: drive requesters, decide ack from link_rdy, then record what happened.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (gap_cnt[i] > 0) begin
        req_valid[i] = 1'b0;
        gap_cnt[i]--;
      end else if (src_pos[i] < src_len[i]) begin
        req_valid[i]         = 1'b1;
        req_data[8*i +: 8]   = src_mem[i][src_pos[i]];
        req_last[i]          = src_lst[i][src_pos[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    #1;
    if (busy && !busy_prev) busy_start = cyc;
    link_ack = (ack_raw || link_rdy) &&
               ((ack_period > 0 && (cyc % ack_period) == 0) ||
                (ack_rel >= 0 && busy && (cyc - busy_start) == ack_rel));
    #1;
    if (link_ack && link_rdy) wr_log.push_back(link_data);
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        rdy_cnt[i]++;
        src_pos[i]++;
        if (i == gap_req && rdy_cnt[i] == gap_after) gap_cnt[i] = gap_len;
      end
    end
    if (timeout) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    if (busy && !link_rdy) hold_lo++;
    if (grant != 4'b0 && prev_grant == 4'b0) begin
      for (int i = 0; i < 4; i++) if (grant[i]) grant_log.push_back(i);
    end
    prev_grant = grant;
    busy_prev  = busy;
  endtask

  task automatic run_until_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      done = !busy;
      for (int i = 0; i < 4; i++) if (src_pos[i] < src_len[i]) done = 1'b0;
    end
    check_eq({tag, "_completed"}, 32'(done), 32'd1);
  endtask

  task automatic compare_logs(input string tag);
    check_eq({tag, "_nbytes"}, wr_log.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      check_eq($sformatf("%s_byte%0d", tag, k), 32'(wr_log[k]), 32'(exp_wr[k]));
    check_eq({tag, "_ngrants"}, grant_log.size(), exp_gnt.size());
    for (int k = 0; k < exp_gnt.size() && k < grant_log.size(); k++)
      check_eq($sformatf("%s_grant%0d", tag, k), grant_log[k], exp_gnt[k]);
  endtask

  initial begin
    bit hit;
    errors = 0; checks = 0; cyc = 0;
    do_reset();
    #1;
    check_eq("reset_grant", 32'(grant), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_link_rdy", 32'(link_rdy), 32'h0);
    check_eq("reset_link_data", 32'(link_data), 32'h0);
    check_eq("reset_ready", 32'(req_ready), 32'h0);
    check_eq("reset_timeout", 32'(timeout), 32'h0);

    // 1: single requester, ack every 4 cycles.
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    ack_period = 4;
    exp_hdr(1); exp_wr.push_back(8'h11); exp_wr.push_back(8'h22); exp_wr.push_back(8'h33);
    exp_gnt.push_back(1);
    run_until_idle("t1");
    compare_logs("t1");
    check_eq("t1_ready1_pulses", rdy_cnt[1], 3);
    check_eq("t1_grant_after", 32'(grant), 32'h0);

    // 2: all four valid with 1-byte packets from rr_ptr=0; req0 has a second packet.
    do_reset();
    push(0, 8'h40, 1'b1); push(0, 8'h50, 1'b1);
    push(1, 8'h41, 1'b1); push(2, 8'h42, 1'b1); push(3, 8'h43, 1'b1);
    ack_period = 1;
    exp_hdr(0); exp_wr.push_back(8'h40); exp_hdr(1); exp_wr.push_back(8'h41);
    exp_hdr(2); exp_wr.push_back(8'h42); exp_hdr(3); exp_wr.push_back(8'h43);
    exp_hdr(0); exp_wr.push_back(8'h50);
    exp_gnt = '{0, 1, 2, 3, 0};
    run_until_idle("t2");
    compare_logs("t2");

    // 3: no reset, rr_ptr is 1. req2 sends 8 bytes without last, req0 one byte.
    clear_model();
    for (int k = 0; k < 8; k++) push(2, 8'h20 + 8'(k), 1'b0);
    push(0, 8'h0F, 1'b1);
    ack_period = 1;
    exp_hdr(2);
    for (int k = 0; k < 4; k++) exp_wr.push_back(8'h20 + 8'(k));
    exp_hdr(0); exp_wr.push_back(8'h0F); exp_hdr(2);
    for (int k = 4; k < 8; k++) exp_wr.push_back(8'h20 + 8'(k));
    exp_gnt = '{2, 0, 2};
    run_until_idle("t3");
    compare_logs("t3");
    check_eq("t3_ready2_pulses", rdy_cnt[2], 8);
    check_eq("t3_ready0_pulses", rdy_cnt[0], 1);

    // 4a: link never acks; pulse in the 8th cycle of the grant.
    do_reset();
    push(1, 8'h77, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      hit = (tmo_cnt > 0);
    end
    check_eq("t4_timeout_seen", 32'(hit), 32'd1);
    check_eq("t4_timeout_cycle", tmo_cyc - busy_start, 7);
    check_eq("t4_no_ready", rdy_cnt[1], 0);
    src_pos[1] = src_len[1];
    step();
    check_eq("t4_idle_busy", 32'(busy), 32'h0);
    check_eq("t4_idle_grant", 32'(grant), 32'h0);
    check_eq("t4_single_pulse", tmo_cnt, 1);

    // 4b: ack lands exactly in the expiry cycle and must win.
    do_reset();
    push(1, 8'h78, 1'b1);
    ack_rel = 7;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      hit = (busy_start >= 0) && (cyc >= busy_start + 10);
    end
    check_eq("t4b_window_reached", 32'(hit), 32'd1);
    check_eq("t4b_no_timeout", tmo_cnt, 0);
    check_eq("t4b_nbytes", wr_log.size(), 1);
    if (wr_log.size() > 0)
      check_eq("t4b_byte", 32'(wr_log[0]), HDR_EN ? 32'hA1 : 32'h78);
    check_eq("t4b_ready1", rdy_cnt[1], HDR_EN ? 0 : 1);

    // 5: req3 drops valid for 5 cycles after two bytes; acks keep coming meanwhile.
    do_reset();
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
    gap_req = 3; gap_after = 2; gap_len = 5;
    ack_period = 1; ack_raw = 1'b1;
    exp_hdr(3);
    for (int k = 0; k < 4; k++) exp_wr.push_back(8'h30 + 8'(k));
    exp_gnt.push_back(3);
    run_until_idle("t5");
    compare_logs("t5");
    check_eq("t5_rdy_low_cycles", hold_lo, 5);
    check_eq("t5_ready3_pulses", rdy_cnt[3], 4);

    // 6: req2 packet (rr_ptr -> 3), then second req2 grant is reset mid-DATA.
    do_reset();
    push(2, 8'h55, 1'b1); push(2, 8'h56, 1'b0); push(2, 8'h57, 1'b0);
    ack_period = 1;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      hit = (rdy_cnt[2] == 2);
    end
    check_eq("t6_reached_data", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; link_ack = 1'b1;
    #2;
    check_eq("t6_rst_cycle_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; link_ack = 1'b0; req_valid = '0; req_last = '0;
    clear_model();
    #2;
    check_eq("t6_post_grant", 32'(grant), 32'h0);
    check_eq("t6_post_busy", 32'(busy), 32'h0);
    check_eq("t6_post_link_rdy", 32'(link_rdy), 32'h0);
    check_eq("t6_post_link_data", 32'(link_data), 32'h0);
    check_eq("t6_post_ready", 32'(req_ready), 32'h0);
    check_eq("t6_post_timeout", 32'(timeout), 32'h0);
    push(1, 8'h66, 1'b1); push(3, 8'h99, 1'b1);
    ack_period = 1;
    exp_hdr(1); exp_wr.push_back(8'h66); exp_hdr(3); exp_wr.push_back(8'h99);
    exp_gnt = '{1, 3};
    run_until_idle("t6");
    compare_logs("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
